avmm_slave_responder: RTL and testbench

//  AVMM slave endpoint answering the 32-bit master that each sector PR user region drives.

---
 rtl/avmm_slave_responder.sv | 114 +++++++++++
 tb/tb_avmm_slave_responder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/avmm_slave_responder.sv
// avmm_slave_responder: AVMM slave terminating sector PR master traffic into scratch memory plus ID/counter registers.
// Ports:
//   clk                      clock
//   rst                      asynchronous reset, active-low
//   avmm_slave_address       byte address (bits [1:0] ignored)
//   avmm_slave_read/write    command strobes, taken when waitrequest is low
//   avmm_slave_writedata     write data
//   avmm_slave_byteenable    per-byte write enable
//   avmm_slave_waitrequest   stall
//   avmm_slave_readdata      read data, held between returns
//   avmm_slave_readdatavalid one pulse per accepted read, READ_LATENCY cycles after accept
//   err_clr                  clears err_sticky
//   err_sticky               unmapped access or simultaneous read+write seen
module avmm_slave_responder #(
    parameter int          ADDR_W       = 20,
    parameter int          DATA_W       = 32,
    parameter int          MEM_WORDS    = 256,
    parameter int          READ_LATENCY = 2,
    parameter int          MAX_PENDING  = 2,
    parameter logic [31:0] ID_VALUE     = 32'h5EC7_0009
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] avmm_slave_address,
    input  logic              avmm_slave_read,
    input  logic              avmm_slave_write,
    input  logic [DATA_W-1:0] avmm_slave_writedata,
    input  logic [3:0]        avmm_slave_byteenable,
    output logic              avmm_slave_waitrequest,
    output logic [DATA_W-1:0] avmm_slave_readdata,
    output logic              avmm_slave_readdatavalid,
    input  logic              err_clr,
    output logic              err_sticky
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = 3;
    localparam logic [ADDR_W-3:0] ID_W = (ADDR_W-2)'('h20000);
    localparam logic [ADDR_W-3:0] WC_W = ID_W + 1'b1;
    localparam logic [ADDR_W-3:0] RC_W = ID_W + 2'd2;

    logic [DATA_W-1:0]       mem_q [MEM_WORDS];
    logic [READ_LATENCY-1:0] v_q;
    logic [DATA_W-1:0]       d_q [READ_LATENCY];
    logic                    hold_q, err_q, err_d;
    logic [PW-1:0]           pend_q, pend_d;
    logic [DATA_W-1:0]       wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic [ADDR_W-3:0]       word_addr;
    logic                    mem_hit, id_hit, wc_hit, rc_hit, mapped;
    logic                    rdv, acc, wr_acc, rd_acc, err_set;
    logic [DATA_W-1:0]       rd_val;

    assign word_addr = avmm_slave_address[ADDR_W-1:2];
    assign mem_hit   = avmm_slave_address < ADDR_W'(MEM_WORDS * 4);
    assign id_hit    = word_addr == ID_W;
    assign wc_hit    = word_addr == WC_W;
    assign rc_hit    = word_addr == RC_W;
    assign mapped    = mem_hit | id_hit | wc_hit | rc_hit;

    assign rdv                      = v_q[READ_LATENCY-1];
    // A return in this cycle frees a slot, so a full pipe need not stall.
    assign avmm_slave_waitrequest   = hold_q | (pend_q == PW'(MAX_PENDING) && !rdv);
    assign avmm_slave_readdatavalid = rdv;
    assign avmm_slave_readdata      = d_q[READ_LATENCY-1];
    assign err_sticky               = err_q;

    assign acc     = (avmm_slave_read | avmm_slave_write) & ~avmm_slave_waitrequest;
    assign wr_acc  = avmm_slave_write & ~avmm_slave_waitrequest;
    // A read colliding with a write is dropped; the write wins.
    assign rd_acc  = avmm_slave_read & ~avmm_slave_write & ~avmm_slave_waitrequest;
    assign err_set = acc & ((avmm_slave_read & avmm_slave_write) | ~mapped);

    always_comb begin
        rd_val   = mem_hit ? mem_q[word_addr[AW-1:0]] :
                   id_hit  ? ID_VALUE :
                   wc_hit  ? wr_cnt_q :
                   rc_hit  ? rd_cnt_q : 32'hDEAD_BEEF;
        wr_cnt_d = (wr_acc & wc_hit) ? '0 : wr_cnt_q + DATA_W'(wr_acc);
        rd_cnt_d = (wr_acc & rc_hit) ? '0 : rd_cnt_q + DATA_W'(rd_acc);
        pend_d   = pend_q + PW'(rd_acc) - PW'(rdv);
        err_d    = err_set | (err_q & ~err_clr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q   <= 1'b1;
            err_q    <= 1'b0;
            pend_q   <= '0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            v_q      <= '0;
            for (int i = 0; i < READ_LATENCY; i++) d_q[i] <= '0;
        end else begin
            hold_q   <= 1'b0;
            err_q    <= err_d;
            pend_q   <= pend_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            v_q[0]   <= rd_acc;
            if (rd_acc) d_q[0] <= rd_val;
            // Data stages load only behind a valid so the output holds its last value.
            for (int i = 1; i < READ_LATENCY; i++) begin
                v_q[i] <= v_q[i-1];
                if (v_q[i-1]) d_q[i] <= d_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc && mem_hit)
            for (int b = 0; b < 4; b++)
                if (avmm_slave_byteenable[b])
                    mem_q[word_addr[AW-1:0]][8*b +: 8] <= avmm_slave_writedata[8*b +: 8];
    end
endmodule

// File: tb/tb_avmm_slave_responder.sv
// tb_avmm_slave_responder: directed table, corner sequences and random traffic against a transaction-level model.
module tb_avmm_slave_responder;
    localparam int L  = 2;
    localparam int MP = 2;
    localparam int MW = 256;

    logic        clk = 0, rst = 1;
    logic [19:0] avmm_slave_address = '0;
    logic        avmm_slave_read = 0, avmm_slave_write = 0, err_clr = 0;
    logic [31:0] avmm_slave_writedata = '0;
    logic [3:0]  avmm_slave_byteenable = '0;
    logic        avmm_slave_waitrequest, avmm_slave_readdatavalid, err_sticky;
    logic [31:0] avmm_slave_readdata;

    always #5 clk = ~clk;

    avmm_slave_responder dut (
        .clk(clk), .rst(rst),
        .avmm_slave_address(avmm_slave_address),
        .avmm_slave_read(avmm_slave_read),
        .avmm_slave_write(avmm_slave_write),
        .avmm_slave_writedata(avmm_slave_writedata),
        .avmm_slave_byteenable(avmm_slave_byteenable),
        .avmm_slave_waitrequest(avmm_slave_waitrequest),
        .avmm_slave_readdata(avmm_slave_readdata),
        .avmm_slave_readdatavalid(avmm_slave_readdatavalid),
        .err_clr(err_clr),
        .err_sticky(err_sticky)
    );

    int n_chk = 0, n_fail = 0;

    typedef struct { int due; logic [31:0] d; } ret_t;
    ret_t        q[$];
    logic [31:0] m_mem [MW];
    logic [31:0] wcnt, rcnt, last_rd;
    bit          m_err, hold, ret_now, seen_rdv;
    int          pend, cyc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset(input int n);
        rst = 0; avmm_slave_read = 0; avmm_slave_write = 0; err_clr = 0;
        q.delete(); pend = 0; m_err = 0; wcnt = 0; rcnt = 0; last_rd = 0; ret_now = 0; hold = 1;
        #1;
        chk("rst_wait_async", avmm_slave_waitrequest, 1);
        chk("rst_rdv_async", avmm_slave_readdatavalid, 0);
        repeat (n) begin
            @(posedge clk); #1;
            chk("rst_wait", avmm_slave_waitrequest, 1);
            chk("rst_rdv", avmm_slave_readdatavalid, 0);
            chk("rst_rdata", avmm_slave_readdata, 0);
            chk("rst_err", err_sticky, 0);
        end
        @(negedge clk);
        rst = 1;
    endtask

    // One bus cycle: drive at negedge, check stall, let the edge happen, update model, check outputs.
    task automatic step(input bit r, input bit w, input logic [19:0] a, input logic [31:0] d,
                        input logic [3:0] be, input bit c);
        bit ew, acc, rok, e;
        int wd;
        logic [31:0] v;
        avmm_slave_read = r; avmm_slave_write = w; avmm_slave_address = a;
        avmm_slave_writedata = d; avmm_slave_byteenable = be; err_clr = c;
        ew = hold || (pend == MP && !ret_now);
        #1;
        chk("waitrequest", avmm_slave_waitrequest, ew);
        @(posedge clk);
        acc = (r || w) && !ew;
        rok = 0; e = 0; v = '0;
        wd = int'(a) >> 2;
        if (acc) begin
            if (w) begin
                if (r) e = 1;
                if (a < MW * 4) begin
                    for (int b = 0; b < 4; b++) if (be[b]) m_mem[wd][8*b +: 8] = d[8*b +: 8];
                end else if (!(wd inside {'h20000, 'h20001, 'h20002})) e = 1;
                wcnt = wcnt + 1;
                if (wd == 'h20001) wcnt = 0;
                if (wd == 'h20002) rcnt = 0;
            end else begin
                if (a < MW * 4) v = m_mem[wd];
                else if (wd == 'h20000) v = 32'h5EC7_0009;
                else if (wd == 'h20001) v = wcnt;
                else if (wd == 'h20002) v = rcnt;
                else begin v = 32'hDEAD_BEEF; e = 1; end
                rcnt = rcnt + 1;
                rok = 1;
            end
        end
        m_err = e || (m_err && !c);
        pend = pend + int'(rok) - int'(ret_now);
        cyc++;
        if (rok) q.push_back('{cyc + L - 1, v});
        ret_now = q.size() > 0 && q[0].due == cyc;
        if (ret_now) begin last_rd = q[0].d; void'(q.pop_front()); end
        hold = 0;
        #1;
        chk("readdatavalid", avmm_slave_readdatavalid, ret_now);
        chk("readdata", avmm_slave_readdata, last_rd);
        chk("err_sticky", err_sticky, m_err);
        seen_rdv = avmm_slave_readdatavalid;
        @(negedge clk);
        avmm_slave_read = 0; avmm_slave_write = 0; err_clr = 0;
    endtask

    task automatic idle();
        step(0, 0, '0, '0, '0, 0);
    endtask

    task automatic drain_expect(input string nm, input logic [31:0] exp);
        int k = 0;
        while (!seen_rdv && k < 8) begin idle(); k++; end
        chk({nm, "_valid"}, avmm_slave_readdatavalid, 1);
        chk(nm, avmm_slave_readdata, exp);
    endtask

    typedef struct { bit r; bit w; logic [19:0] a; logic [31:0] d; logic [3:0] be; logic [31:0] exp; } vec_t;
    vec_t tbl [16];

    initial begin
        int pulses;
        tbl[0]  = '{0, 1, 20'h00010, 32'hA5A5_1234, 4'hF, 32'h0};
        tbl[1]  = '{0, 1, 20'h00010, 32'h0000_FF00, 4'h2, 32'h0};
        tbl[2]  = '{1, 0, 20'h00010, 32'h0,         4'h0, 32'hA5A5_FF34};
        tbl[3]  = '{1, 0, 20'h80000, 32'h0,         4'h0, 32'h5EC7_0009};
        tbl[4]  = '{0, 1, 20'h80004, 32'h0,         4'h0, 32'h0};
        tbl[5]  = '{0, 1, 20'h00020, 32'h1,         4'hF, 32'h0};
        tbl[6]  = '{0, 1, 20'h00024, 32'h2,         4'hF, 32'h0};
        tbl[7]  = '{0, 1, 20'h00028, 32'h3,         4'hF, 32'h0};
        tbl[8]  = '{1, 0, 20'h80004, 32'h0,         4'h0, 32'h3};
        tbl[9]  = '{0, 1, 20'h80004, 32'hFFFF_FFFF, 4'hF, 32'h0};
        tbl[10] = '{1, 0, 20'h80004, 32'h0,         4'h0, 32'h0};
        tbl[11] = '{0, 1, 20'h80008, 32'h0,         4'h1, 32'h0};
        tbl[12] = '{1, 0, 20'h80008, 32'h0,         4'h0, 32'h0};
        tbl[13] = '{1, 0, 20'h80008, 32'h0,         4'h0, 32'h1};
        tbl[14] = '{1, 0, 20'h00013, 32'h0,         4'h0, 32'hA5A5_FF34};
        tbl[15] = '{1, 0, 20'h40000, 32'h0,         4'h0, 32'hDEAD_BEEF};
        cyc = 0;
        #2;
        do_reset(5);
        idle();
        chk("wait_release", avmm_slave_waitrequest, 0);

        for (int i = 0; i < MW; i++) step(0, 1, 20'(i * 4), $urandom, 4'hF, 0);

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].be, 0);
            if (tbl[i].r) drain_expect($sformatf("tbl%0d", i), tbl[i].exp);
        end
        chk("err_after_unmapped", err_sticky, 1);

        step(0, 1, 20'h00014, 32'h1234_5678, 4'hF, 0);
        step(0, 1, 20'h00014, 32'hFFFF_FFFF, 4'h0, 0);
        step(1, 0, 20'h00014, '0, '0, 0);
        drain_expect("be_zero_noop", 32'h1234_5678);

        pulses = 0;
        step(1, 0, 20'h0, '0, '0, 0); pulses += int'(seen_rdv);
        step(1, 0, 20'h4, '0, '0, 0); pulses += int'(seen_rdv);
        chk("b2b_no_stall", avmm_slave_waitrequest, 0);
        step(1, 0, 20'h8, '0, '0, 0); pulses += int'(seen_rdv);
        idle(); pulses += int'(seen_rdv);
        idle(); pulses += int'(seen_rdv);
        chk("b2b_pulses", 32'(pulses), 3);

        step(0, 0, '0, '0, '0, 1);
        chk("err_clr", err_sticky, 0);
        step(1, 1, 20'h00030, 32'hCAFE_0001, 4'hF, 0);
        idle(); idle();
        chk("rw_err", err_sticky, 1);
        step(1, 0, 20'h40000, '0, '0, 1);
        chk("clr_vs_new_err", err_sticky, 1);
        idle(); idle();
        step(1, 0, 20'h00030, '0, '0, 0);
        drain_expect("rw_write_done", 32'hCAFE_0001);

        step(1, 0, 20'h0, '0, '0, 0);
        step(1, 0, 20'h4, '0, '0, 0);
        do_reset(2);
        idle();
        for (int i = 0; i < 3; i++) step(1, 0, 20'(i * 4), '0, '0, 0);
        idle(); idle(); idle();

        for (int n = 0; n < 3000; n++) begin
            logic [19:0] a;
            int sel = $urandom_range(0, 9);
            a = sel < 6 ? 20'($urandom_range(0, MW * 4 - 1)) :
                sel == 6 ? 20'h80000 | 20'($urandom_range(0, 3)) :
                sel == 7 ? 20'h80004 : sel == 8 ? 20'h80008 : 20'($urandom);
            if ($urandom_range(0, 599) == 0) begin do_reset(2); idle(); end
            step($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, a, $urandom,
                 4'($urandom), $urandom_range(0, 15) == 0);
        end
        idle(); idle(); idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
